// File: rtl/uart_console_pkg.sv
// Shared definitions for the uart_console serial transmit peripheral:
// register offsets, STATUS layout and the transmit FSM state encoding.
package uart_console_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int STATUS_BUSY_BIT  = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_EMPTY_BIT = 2;
  localparam int STATUS_LEVEL_LSB = 8;
  localparam int STATUS_LEVEL_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] pack_status(
    input logic                      busy,
    input logic                      full,
    input logic                      empty,
    input logic [STATUS_LEVEL_W-1:0] level
  );
    logic [31:0] word;
    word = '0;
    word[STATUS_BUSY_BIT]  = busy;
    word[STATUS_FULL_BIT]  = full;
    word[STATUS_EMPTY_BIT] = empty;
    word[STATUS_LEVEL_LSB +: STATUS_LEVEL_W] = level;
    return word;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO with a registered occupancy count.
// Pushes while full and pops while empty are discarded.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    full     = (count_q == FULL_COUNT);
    empty    = (count_q == '0);
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = count_q;

endmodule

// File: rtl/uart_console.sv
// 8N1 transmit-only console on the PicoRV32 native bus: TXDATA/STATUS/DIV
// registers, a byte FIFO and a start/data/stop shifting FSM driving txd.
module uart_console
  import uart_console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
  parameter logic [15:0] CLK_DIV    = 16'd868,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        txd
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e   state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] frame_div_q, frame_div_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        mem_ready_q, mem_ready_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [LW-1:0] fifo_level;

  logic [1:0]  reg_sel;
  logic        push_req, wr_fire, busy;
  logic [15:0] div_merged;
  logic [31:0] rd_word;

  // Slave select is done by the interconnect, so the base and the
  // undecoded bus bits are intentionally unused here.
  logic unused_bus;
  assign unused_bus = ^{BASE_ADDR, mem_instr, mem_addr[31:4], mem_addr[1:0],
                        mem_wdata[31:16], mem_wstrb[3:2]};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (mem_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Handshake: valid is held by the master until ready; ready is a single
  // registered pulse one cycle after acceptance, and register side effects
  // happen in that ready cycle. A TXDATA push into a full FIFO is not
  // accepted until the cycle in which the FSM pops a slot free.
  always_comb begin
    reg_sel     = mem_addr[3:2];
    push_req    = mem_valid && (reg_sel == REG_TXDATA) && mem_wstrb[0];
    wr_fire     = mem_valid && mem_ready_q && (mem_wstrb != 4'b0000);
    fifo_push   = mem_ready_q && push_req;
    mem_ready_d = mem_valid && !mem_ready_q &&
                  !(push_req && fifo_full && !fifo_pop);
    div_merged  = {mem_wstrb[1] ? mem_wdata[15:8] : div_q[15:8],
                   mem_wstrb[0] ? mem_wdata[7:0]  : div_q[7:0]};
    div_d       = div_q;
    if (wr_fire && (reg_sel == REG_DIV) && (mem_wstrb[1:0] != 2'b00)) begin
      div_d = (div_merged == 16'd0) ? 16'd1 : div_merged;
    end
  end

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      REG_STATUS: rd_word = pack_status(busy, fifo_full, fifo_empty,
                                        STATUS_LEVEL_W'(fifo_level));
      REG_DIV:    rd_word = {16'h0000, div_q};
      default:    rd_word = '0;
    endcase
  end

  assign mem_ready = mem_ready_q;
  assign mem_rdata = mem_ready_q ? rd_word : 32'h0000_0000;
  assign txd       = txd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= CLK_DIV;
      frame_div_q <= CLK_DIV;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      txd_q       <= 1'b1;
      mem_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      frame_div_q <= frame_div_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      txd_q       <= txd_d;
      mem_ready_q <= mem_ready_d;
    end
  end

  // Each state lasts frame_div_q cycles: the timer is loaded with
  // period-1 on entry and the state advances when it reaches zero.
  always_comb begin
    state_d     = state_q;
    frame_div_d = frame_div_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop    = 1'b1;
          shift_d     = fifo_dout;
          frame_div_d = div_q;
          timer_d     = div_q - 16'd1;
          state_d     = START;
        end
      end
      START: begin
        if (timer_q == 16'd0) begin
          timer_d   = frame_div_q - 16'd1;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      DATA: begin
        if (timer_q == 16'd0) begin
          timer_d = frame_div_q - 16'd1;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      STOP: begin
        if (timer_q == 16'd0) begin
          if (!fifo_empty) begin
            // Chain straight into the next frame with no idle gap.
            fifo_pop    = 1'b1;
            shift_d     = fifo_dout;
            frame_div_d = div_q;
            timer_d     = div_q - 16'd1;
            state_d     = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // txd is registered from the next state so it lines up with state_q.
  always_comb begin
    busy  = (state_q != IDLE);
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_console.sv
// Self-checking bench for uart_console: bus driver tasks, a txd frame
// monitor scored against an expected-frame queue, and per-feature tests.
module tb_uart_console;

  localparam logic [31:0] A_TXDATA = 32'h2000_0000;
  localparam logic [31:0] A_STATUS = 32'h2000_0004;
  localparam logic [31:0] A_DIV    = 32'h2000_0008;
  localparam logic [31:0] A_RSVD   = 32'h2000_000C;
  localparam logic [15:0] RESET_DIV = 16'd868;

  logic        clk, rst;
  logic        mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        txd;

  int          tests_run = 0;
  int          tests_failed = 0;
  int unsigned cyc = 0;
  int          frames_done = 0;

  // Each entry is {bit period, byte}; start_q records frame start cycles.
  logic [23:0] exp_q[$];
  int unsigned start_q[$];

  uart_console #(
    .BASE_ADDR  (32'h2000_0000),
    .CLK_DIV    (RESET_DIV),
    .FIFO_DEPTH (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .txd       (txd)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata,
                          output int unsigned req_c, output int unsigned rdy_c);
    bit timed_out;
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    req_c     = cyc;
    rdy_c     = 0;
    rdata     = '0;
    timed_out = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin
        timed_out = 1'b0;
        rdata     = mem_rdata;
        rdy_c     = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    tests_run++;
    if (timed_out) begin
      tests_failed++;
      $display("FAIL bus_timeout: addr=%h no mem_ready within 4000 cycles, required a completion", addr);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, output int unsigned req_c,
                           output int unsigned rdy_c);
    logic [31:0] unused_rd;
    bus_xfer(addr, wdata, wstrb, unused_rd, req_c, rdy_c);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] rdata);
    int unsigned rq, rd;
    bus_xfer(addr, 32'h0, 4'h0, rdata, rq, rd);
  endtask

  task automatic wait_frames(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frames_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scoreboard: txd frame monitor ----------------
  always begin : txd_monitor
    logic [23:0] ent;
    logic [15:0] fdiv;
    logic [9:0]  pattern;
    bit          bad, aborted;
    int          bad_pos;
    logic        seen;
    @(negedge clk);
    if (rst === 1'b0 && txd === 1'b0) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_frame: txd=0 at cycle %0d, required idle (no frame queued)", cyc);
        for (int i = 0; i < 20000 && txd !== 1'b1; i++) @(negedge clk);
      end else begin
        ent     = exp_q.pop_front();
        fdiv    = ent[23:8];
        pattern = {1'b1, ent[7:0], 1'b0};
        start_q.push_back(cyc);
        bad     = 1'b0;
        aborted = 1'b0;
        bad_pos = 0;
        seen    = 1'b0;
        for (int i = 0; i < 10 * int'(fdiv); i++) begin
          if (i != 0) @(negedge clk);
          if (rst !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          if (!bad && txd !== pattern[i / int'(fdiv)]) begin
            bad     = 1'b1;
            bad_pos = i;
            seen    = txd;
          end
        end
        if (!aborted) begin
          tests_run++;
          if (bad) begin
            tests_failed++;
            $display("FAIL frame_%02h: txd=%b at offset %0d (div %0d), required %b",
                     ent[7:0], seen, bad_pos, fdiv, pattern[bad_pos / int'(fdiv)]);
          end
          frames_done++;
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd;
    bit txd_bad, rdy_bad;
    txd_bad = 1'b0;
    rdy_bad = 1'b0;
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (txd !== 1'b1) txd_bad = 1'b1;
      if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) rdy_bad = 1'b1;
    end
    tests_run++;
    if (txd_bad) begin
      tests_failed++;
      $display("FAIL reset_txd: txd=%b during reset, required 1", txd);
    end
    tests_run++;
    if (rdy_bad) begin
      tests_failed++;
      $display("FAIL reset_bus: mem_ready=%b mem_rdata=%h during reset, required 0/0", mem_ready, mem_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== 32'h0000_0004) begin
      tests_failed++;
      $display("FAIL reset_status: got %h, required 00000004", rd);
    end
    bus_read(A_DIV, rd);
    tests_run++;
    if (rd !== {16'h0, RESET_DIV}) begin
      tests_failed++;
      $display("FAIL reset_div: got %h, required %h", rd, {16'h0, RESET_DIV});
    end
    tests_run++;
    if (txd !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_idle_txd: txd=%b, required 1", txd);
    end
  endtask

  task automatic test_single_byte();
    logic [31:0] rd;
    int unsigned rq, ry;
    bit ok;
    int target;
    bus_write(A_DIV, 32'd4, 4'b0011, rq, ry);
    bus_read(A_DIV, rd);
    tests_run++;
    if (rd !== 32'd4) begin
      tests_failed++;
      $display("FAIL div_write: got %h, required 00000004", rd);
    end
    start_q.delete();
    target = frames_done + 1;
    exp_q.push_back({16'd4, 8'hA5});
    bus_write(A_TXDATA, 32'h0000_00A5, 4'b0001, rq, ry);
    wait_frames(target, 200, ok);
    tests_run++;
    if (!ok || start_q.size() < 1) begin
      tests_failed++;
      $display("FAIL single_frame_done: frames=%0d, required %0d within 200 cycles", frames_done, target);
    end else if (start_q[0] != ry + 2) begin
      tests_failed++;
      $display("FAIL first_start_latency: start cycle %0d, required %0d (ready+2)", start_q[0], ry + 2);
    end
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== 32'h0000_0004) begin
      tests_failed++;
      $display("FAIL single_status_idle: got %h, required 00000004", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int unsigned rq, ry;
    bit ok;
    int target;
    bus_write(A_DIV, 32'd2, 4'b0011, rq, ry);
    start_q.delete();
    target = frames_done + 2;
    exp_q.push_back({16'd2, 8'h00});
    exp_q.push_back({16'd2, 8'hFF});
    bus_write(A_TXDATA, 32'h0000_0000, 4'b0001, rq, ry);
    bus_write(A_TXDATA, 32'h0000_00FF, 4'b0001, rq, ry);
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== 32'h0000_0101) begin
      tests_failed++;
      $display("FAIL b2b_status_busy: got %h, required 00000101", rd);
    end
    wait_frames(target, 300, ok);
    tests_run++;
    if (!ok || start_q.size() < 2) begin
      tests_failed++;
      $display("FAIL b2b_frames: frames=%0d, required %0d within 300 cycles", frames_done, target);
    end else if (start_q[1] != start_q[0] + 20) begin
      tests_failed++;
      $display("FAIL b2b_contiguous: second start %0d, required %0d", start_q[1], start_q[0] + 20);
    end
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== 32'h0000_0004) begin
      tests_failed++;
      $display("FAIL b2b_status_idle: got %h, required 00000004", rd);
    end
  endtask

  task automatic test_full_stall();
    logic [31:0] rd;
    int unsigned rq[18];
    int unsigned ry[18];
    logic [7:0]  b;
    bit ok, early_stall;
    int target;
    int bad_k;
    bus_write(A_DIV, 32'd8, 4'b0011, rq[0], ry[0]);
    start_q.delete();
    target = frames_done + 18;
    for (int k = 0; k < 18; k++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back({16'd8, b});
      bus_write(A_TXDATA, {24'h0, b}, 4'b0001, rq[k], ry[k]);
    end
    early_stall = 1'b0;
    bad_k = 0;
    for (int k = 0; k < 17; k++) begin
      if (!early_stall && ry[k] != rq[k] + 1) begin
        early_stall = 1'b1;
        bad_k = k;
      end
    end
    tests_run++;
    if (early_stall) begin
      tests_failed++;
      $display("FAIL nonfull_write_latency: write %0d ready %0d, required %0d", bad_k, ry[bad_k], rq[bad_k] + 1);
    end
    tests_run++;
    if (start_q.size() < 1) begin
      tests_failed++;
      $display("FAIL stall_first_frame: no frame started, required one");
    end else if (ry[17] != start_q[0] + 80) begin
      tests_failed++;
      $display("FAIL stall_release: ready at %0d, required %0d (cycle after first pop)", ry[17], start_q[0] + 80);
    end
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== 32'h0000_1003) begin
      tests_failed++;
      $display("FAIL full_status: got %h, required 00001003", rd);
    end
    wait_frames(target, 18 * 80 + 300, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL stall_frames: frames=%0d, required %0d", frames_done, target);
    end
  endtask

  task automatic test_div_change();
    logic [31:0] rd;
    int unsigned rq, ry;
    bit ok, started;
    int target;
    bus_write(A_DIV, 32'd4, 4'b0011, rq, ry);
    start_q.delete();
    target = frames_done + 2;
    exp_q.push_back({16'd4, 8'h55});
    bus_write(A_TXDATA, 32'h0000_0055, 4'b0001, rq, ry);
    started = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (start_q.size() > 0 && cyc >= start_q[0] + 15) begin
        started = 1'b1;
        break;
      end
    end
    bus_write(A_DIV, 32'd2, 4'b0011, rq, ry);
    exp_q.push_back({16'd2, 8'h3C});
    bus_write(A_TXDATA, 32'h0000_003C, 4'b0001, rq, ry);
    wait_frames(target, 300, ok);
    tests_run++;
    if (!started || !ok || start_q.size() < 2) begin
      tests_failed++;
      $display("FAIL div_change_frames: frames=%0d, required %0d", frames_done, target);
    end else if (start_q[1] != start_q[0] + 40) begin
      tests_failed++;
      $display("FAIL div_change_len: second start %0d, required %0d", start_q[1], start_q[0] + 40);
    end
    bus_write(A_DIV, 32'd0, 4'b0011, rq, ry);
    bus_read(A_DIV, rd);
    tests_run++;
    if (rd !== 32'd1) begin
      tests_failed++;
      $display("FAIL div_zero: got %h, required 00000001", rd);
    end
  endtask

  task automatic test_regs();
    logic [31:0] rd;
    int unsigned rq, ry;
    bit held_bad;
    bus_write(A_DIV, 32'h0000_0300, 4'b0010, rq, ry);
    bus_read(A_DIV, rd);
    tests_run++;
    if (rd !== 32'h0000_0301) begin
      tests_failed++;
      $display("FAIL div_byte_strobe: got %h, required 00000301", rd);
    end
    bus_write(A_STATUS, 32'hFFFF_FFFF, 4'b1111, rq, ry);
    bus_write(A_TXDATA, 32'h0000_5A5A, 4'b0010, rq, ry);
    bus_write(A_RSVD, 32'hFFFF_FFFF, 4'b1111, rq, ry);
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== 32'h0000_0004) begin
      tests_failed++;
      $display("FAIL ignored_writes_status: got %h, required 00000004", rd);
    end
    bus_read(A_TXDATA, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL txdata_read: got %h, required 00000000", rd);
    end
    bus_read(A_RSVD, rd);
    tests_run++;
    if (rd !== 32'h0) begin
      tests_failed++;
      $display("FAIL reserved_read: got %h, required 00000000", rd);
    end
    // Hold a read request one extra cycle: ready must not repeat back to back.
    @(posedge clk); #1;
    mem_valid = 1'b1;
    mem_addr  = A_DIV;
    mem_wstrb = 4'h0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) break;
    end
    @(negedge clk);
    held_bad = (mem_ready !== 1'b0);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    tests_run++;
    if (held_bad) begin
      tests_failed++;
      $display("FAIL ready_single_pulse: mem_ready high two cycles in a row, required a one-cycle pulse");
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd;
    int unsigned rq, ry;
    bit started, txd_bad;
    bus_write(A_DIV, 32'd4, 4'b0011, rq, ry);
    start_q.delete();
    exp_q.push_back({16'd4, 8'h0F});
    exp_q.push_back({16'd4, 8'h33});
    exp_q.push_back({16'd4, 8'hC3});
    bus_write(A_TXDATA, 32'h0000_000F, 4'b0001, rq, ry);
    bus_write(A_TXDATA, 32'h0000_0033, 4'b0001, rq, ry);
    bus_write(A_TXDATA, 32'h0000_00C3, 4'b0001, rq, ry);
    started = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (start_q.size() > 0 && cyc >= start_q[0] + 25) begin
        started = 1'b1;
        break;
      end
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (!started || txd !== 1'b1 || mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_midframe_outputs: started=%b txd=%b ready=%b rdata=%h, required 1/1/0/0",
               started, txd, mem_ready, mem_rdata);
    end
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus_read(A_STATUS, rd);
    tests_run++;
    if (rd !== 32'h0000_0004) begin
      tests_failed++;
      $display("FAIL reset_midframe_status: got %h, required 00000004", rd);
    end
    bus_read(A_DIV, rd);
    tests_run++;
    if (rd !== {16'h0, RESET_DIV}) begin
      tests_failed++;
      $display("FAIL reset_midframe_div: got %h, required %h", rd, {16'h0, RESET_DIV});
    end
    txd_bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (txd !== 1'b1) txd_bad = 1'b1;
    end
    tests_run++;
    if (txd_bad) begin
      tests_failed++;
      $display("FAIL reset_midframe_quiet: txd went low after reset, required idle high");
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst       = 1'b1;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_stall();
    test_div_change();
    test_regs();
    test_reset_midframe();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d frames still expected, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
